// File: rtl/triage_dispatcher.sv
// Doctor-side dispatcher: pulls the next patient from the priority queue, holds it
// for a priority-scaled treatment time, then pulses discharge and counts it served.
module triage_dispatcher #(
  parameter int TREAT_BASE = 4,
  parameter int DEQ_LAT    = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             doc_ready,
  input  logic [3:0]       q_count,
  input  logic [3:0]       q_out,
  output logic             deq_req,
  output logic [1:0]       cur_pri,
  output logic [1:0]       cur_id,
  output logic             busy,
  output logic             discharge,
  output logic [5:0]       treat_left,
  output logic [CNT_W-1:0] served
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, LATCH, TREAT, DONE} state_t;

  localparam logic [5:0]       BASE6     = 6'(TREAT_BASE);
  localparam logic [1:0]       WAIT_INIT = 2'(DEQ_LAT - 1);
  localparam logic [CNT_W-1:0] SRV_MAX   = '1;

  state_t     state;
  logic [1:0] wait_cnt;
  logic [5:0] dur;

  // Full 6-bit product: TREAT_BASE*4 fits for any legal TREAT_BASE.
  always_comb dur = BASE6 * ({4'd0, q_out[3:2]} + 6'd1);

  // Each state's actions land on the edge that leaves it, so the registered
  // outputs appear in the following state (busy/treat_left show during TREAT,
  // discharge and the new served count show during DONE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      deq_req    <= 1'b0;
      cur_pri    <= '0;
      cur_id     <= '0;
      busy       <= 1'b0;
      discharge  <= 1'b0;
      treat_left <= '0;
      served     <= '0;
    end else begin
      deq_req   <= 1'b0;
      discharge <= 1'b0;
      case (state)
        IDLE: begin
          if (doc_ready && (q_count != 4'd0)) begin
            state   <= REQ;
            deq_req <= 1'b1;
          end
        end
        REQ: begin
          wait_cnt <= WAIT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) state <= LATCH;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        LATCH: begin
          cur_pri    <= q_out[3:2];
          cur_id     <= q_out[1:0];
          treat_left <= dur;
          busy       <= 1'b1;
          state      <= TREAT;
        end
        TREAT: begin
          treat_left <= treat_left - 6'd1;
          if (treat_left == 6'd1) begin
            state     <= DONE;
            busy      <= 1'b0;
            discharge <= 1'b1;
            if (served != SRV_MAX) served <= served + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triage_dispatcher.sv
// Bench for triage_dispatcher: two builds (DEQ_LAT=1 and 3) share stimulus and are
// checked every cycle against an offset-based timeline model, plus literal checks.
module tb_triage_dispatcher;
  localparam int TB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       doc_ready;
  logic [3:0] q_count, q_out;
  logic       deq[2], dis[2], busy[2];
  logic [1:0] pri[2], id[2];
  logic [5:0] tl[2];
  logic [7:0] srv[2];

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  triage_dispatcher #(.TREAT_BASE(TB), .DEQ_LAT(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .doc_ready(doc_ready), .q_count(q_count), .q_out(q_out),
    .deq_req(deq[0]), .cur_pri(pri[0]), .cur_id(id[0]), .busy(busy[0]),
    .discharge(dis[0]), .treat_left(tl[0]), .served(srv[0]));

  triage_dispatcher #(.TREAT_BASE(TB), .DEQ_LAT(3), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .doc_ready(doc_ready), .q_count(q_count), .q_out(q_out),
    .deq_req(deq[1]), .cur_pri(pri[1]), .cur_id(id[1]), .busy(busy[1]),
    .discharge(dis[1]), .treat_left(tl[1]), .served(srv[1]));

  task automatic chk(input int u, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL u%0d %s actual=%0d required=%0d at %0t", u, nm, act, exp, $time);
    end
  endtask

  // Model: a patient occupies a timeline of offsets measured from the REQ cycle.
  // off 0 = REQ, DEQ_LAT wait cycles, one latch cycle, T treatment cycles, one done cycle.
  logic       m_act[2];
  int         m_off[2];
  logic [1:0] m_pri[2], m_id[2];
  int         m_srv[2];

  function automatic int dl(input int u);
    return (u == 0) ? 1 : 3;
  endfunction
  function automatic int tdur(input logic [1:0] p);
    return TB * (int'(p) + 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        m_act[u] <= 1'b0; m_off[u] <= 0; m_pri[u] <= '0; m_id[u] <= '0; m_srv[u] <= 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (!m_act[u]) begin
          if (doc_ready && q_count != 4'd0) begin m_act[u] <= 1'b1; m_off[u] <= 0; end
        end else begin
          m_off[u] <= m_off[u] + 1;
          if (m_off[u] + 1 == dl(u) + 2) begin m_pri[u] <= q_out[3:2]; m_id[u] <= q_out[1:0]; end
          if (m_off[u] + 1 == dl(u) + 2 + tdur(m_pri[u])) m_srv[u] <= (m_srv[u] == 255) ? 255 : m_srv[u] + 1;
          if (m_off[u] + 1 == dl(u) + 3 + tdur(m_pri[u])) m_act[u] <= 1'b0;
        end
      end
    end
  end

  function automatic logic e_busy(input int u);
    return m_act[u] && m_off[u] >= dl(u) + 2 && m_off[u] <= dl(u) + 1 + tdur(m_pri[u]);
  endfunction
  function automatic int e_tl(input int u);
    return e_busy(u) ? dl(u) + 2 + tdur(m_pri[u]) - m_off[u] : 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        chk(u, "deq_req",    deq[u],  32'(m_act[u] && m_off[u] == 0));
        chk(u, "busy",       busy[u], 32'(e_busy(u)));
        chk(u, "treat_left", tl[u],   32'(e_tl(u)));
        chk(u, "discharge",  dis[u],  32'(m_act[u] && m_off[u] == dl(u) + 2 + tdur(m_pri[u])));
        chk(u, "cur_pri",    pri[u],  32'(m_pri[u]));
        chk(u, "cur_id",     id[u],   32'(m_id[u]));
        chk(u, "served",     srv[u],  32'(m_srv[u]));
      end
    end
  end

  // Run-observation state, filled by run() for unit 0 (plus unit 1 latency marks).
  logic [3:0] words[$];
  int ndeq, ndis, u1_deq, u1_busy;
  int blen[8], ftl[8];
  logic [1:0] ps[8], is[8];

  task automatic run(input int max_cyc, input int n_dis, input bit consume, input bit drop);
    int n;
    logic pb, pb1;
    ndeq = 0; ndis = 0; n = 0; u1_deq = -1; u1_busy = -1;
    pb = busy[0]; pb1 = busy[1];
    foreach (blen[i]) begin blen[i] = 0; ftl[i] = 0; ps[i] = '0; is[i] = '0; end
    while (ndis < n_dis && n < max_cyc) begin
      @(negedge clk); n++;
      if (deq[0]) begin ndeq++; if (consume && q_count != 4'd0) q_count = q_count - 4'd1; end
      if (deq[1] && u1_deq < 0) u1_deq = n;
      if (busy[1] && !pb1 && u1_busy < 0) u1_busy = n;
      if (busy[0] && !pb && ndis < 8) begin
        ftl[ndis] = int'(tl[0]); ps[ndis] = pri[0]; is[ndis] = id[0];
        if (words.size() > 0) q_out = words.pop_front();
        if (drop) doc_ready = 1'b0;
      end
      if (busy[0] && ndis < 8) blen[ndis]++;
      if (dis[0]) ndis++;
      pb = busy[0]; pb1 = busy[1];
    end
    if (ndis < n_dis) chk(0, "timeout_discharges", ndis, n_dis);
  endtask

  task automatic do_reset();
    @(negedge clk); q_count = 4'd0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int cnt;
    bit found;
    rst = 1'b1; doc_ready = 1'b0; q_count = 4'd0; q_out = 4'd0;
    @(negedge clk); chk_en = 1'b1;
    @(negedge clk);
    chk(0, "rst_served", srv[0], 0); chk(0, "rst_busy", busy[0], 0);
    chk(0, "rst_deq", deq[0], 0);    chk(0, "rst_tl", tl[0], 0);
    rst = 1'b0;

    // Empty queue with a ready doctor: nothing is ever requested.
    doc_ready = 1'b1; cnt = 0;
    repeat (20) begin @(negedge clk); if (deq[0] || deq[1]) cnt++; end
    chk(0, "empty_no_deq", cnt, 0);
    chk(0, "empty_busy", busy[0], 0);
    chk(0, "empty_served", srv[0], 0);

    // Single patient, priority 2 -> 12 treatment cycles.
    q_out = 4'b1010; q_count = 4'd1;
    run(100, 1, 1'b1, 1'b0);
    chk(0, "p1_ndeq", ndeq, 1);
    chk(0, "p1_busy_len", blen[0], 12);
    chk(0, "p1_first_tl", ftl[0], 12);
    chk(0, "p1_pri", ps[0], 2);
    chk(0, "p1_id", is[0], 2);
    chk(0, "p1_served", srv[0], 1);
    chk(1, "lat3_req_to_busy", u1_busy - u1_deq, 5);
    repeat (10) @(negedge clk);

    // Back-to-back: priority 3 (16 cycles) then priority 0 (4 cycles).
    do_reset();
    words = '{4'b0011}; q_out = 4'b1101; q_count = 4'd2;
    run(200, 2, 1'b1, 1'b0);
    chk(0, "b2b_ndeq", ndeq, 2);
    chk(0, "b2b_len0", blen[0], 16);
    chk(0, "b2b_len1", blen[1], 4);
    chk(0, "b2b_pri0", ps[0], 3); chk(0, "b2b_id0", is[0], 1);
    chk(0, "b2b_pri1", ps[1], 0); chk(0, "b2b_id1", is[1], 3);
    chk(0, "b2b_served", srv[0], 2);
    cnt = 0;
    repeat (30) begin @(negedge clk); if (deq[0]) cnt++; end
    chk(0, "b2b_no_third", cnt, 0);

    // doc_ready drops mid-treatment: patient still discharged, then no request.
    do_reset();
    words = {}; q_out = 4'b0110; q_count = 4'd2; doc_ready = 1'b1;
    run(100, 1, 1'b1, 1'b1);
    chk(0, "drop_len", blen[0], 8);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (deq[0]) cnt++; end
    chk(0, "drop_no_deq", cnt, 0);
    doc_ready = 1'b1;
    run(100, 1, 1'b1, 1'b0);
    chk(0, "resume_ndeq", ndeq, 1);
    repeat (10) @(negedge clk);

    // Asynchronous reset while treat_left == 5.
    do_reset();
    q_out = 4'b0100; q_count = 4'd1; doc_ready = 1'b1; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (tl[0] == 6'd5) found = 1'b1;
    end
    chk(0, "reached_tl5", found, 1);
    #2 rst = 1'b1;
    #1;
    chk(0, "arst_busy", busy[0], 0); chk(0, "arst_tl", tl[0], 0);
    chk(0, "arst_pri", pri[0], 0);   chk(0, "arst_id", id[0], 0);
    chk(0, "arst_dis", dis[0], 0);   chk(0, "arst_deq", deq[0], 0);
    @(negedge clk); rst = 1'b0; q_count = 4'd0;
    cnt = 0;
    repeat (15) begin @(negedge clk); if (dis[0]) cnt++; end
    chk(0, "arst_no_dis", cnt, 0);
    chk(0, "arst_served", srv[0], 0);

    // Saturation: 257 discharges on unit 0, served holds at 255.
    do_reset();
    q_out = 4'b0000; q_count = 4'd1; doc_ready = 1'b1;
    run(4000, 257, 1'b0, 1'b0);
    chk(0, "sat_served", srv[0], 255);
    repeat (800) @(negedge clk);
    chk(1, "sat_served", srv[1], 255);
    q_count = 4'd0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/triage_dispatcher.md
Name: triage_dispatcher

Overview:
- Consumer (read) end of the emergency-room priority queue: the doctor-side dispatcher that pulls the next patient out of the queue.
- When the doctor is ready and the queue is non-empty, it issues a one-cycle dequeue request.
- It captures the returned 4-bit patient word (priority[3:2], ID[1:0]) and holds it on display for a priority-dependent treatment time.
- It then signals discharge and counts patients served.

Parameters:
- TREAT_BASE, 4, treatment cycles per priority level; duration = TREAT_BASE*(priority+1).
- DEQ_LAT, 1, cycles from deq_req to valid q_out (range 1..3).
- CNT_W, 8, width of served counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- doc_ready  input  1  level: doctor free to take next patient.
- q_count  input  4  patient count reported by queue.
- q_out  input  4  queue output word {priority[1:0], id[1:0]}.
- deq_req  output  1  one-cycle dequeue strobe (drives queue ende=1).
- cur_pri  output  2  priority of patient under treatment.
- cur_id  output  2  ID of patient under treatment.
- busy  output  1  high while a patient is held (LATCH..TREAT).
- discharge  output  1  one-cycle pulse at end of treatment.
- treat_left  output  6  remaining treatment cycles.
- served  output  CNT_W  total patients discharged, saturating.

Behaviour:
- Reset (async, any state): FSM=IDLE; deq_req=0, cur_pri=0, cur_id=0, busy=0, discharge=0, treat_left=0, served=0.
- States: IDLE, REQ, WAIT, LATCH, TREAT, DONE.
- IDLE: if doc_ready=1 and q_count!=0 -> REQ next edge; otherwise stay. Neither input is sampled in any other state.
- REQ: deq_req=1 for exactly this one cycle. Load wait counter with DEQ_LAT-1 -> WAIT.
- WAIT: decrement; at 0 -> LATCH. With DEQ_LAT=1, WAIT lasts one cycle.
- LATCH: capture cur_pri=q_out[3:2], cur_id=q_out[1:0]; treat_left=TREAT_BASE*(q_out[3:2]+1); busy=1 -> TREAT.
- TREAT: treat_left decrements by 1 per cycle; when treat_left==1 -> DONE next edge (treat_left reaches 0 there).
- DONE: discharge=1 for one cycle; busy=0; served += 1, holding at 2^CNT_W-1 once reached; cur_pri/cur_id retain last values -> IDLE.
- Request-to-request latency: minimum IDLE->IDLE cycle = 1+DEQ_LAT+1+TREAT_BASE*(pri+1)+1 cycles. deq_req is never asserted twice without an intervening DONE.
- doc_ready falling during REQ..DONE is ignored; the current treatment completes.
- q_count dropping to 0 after REQ: the captured word is still treated (queue contract guarantees data for an accepted request).
- q_count=0 with doc_ready=1: stay in IDLE, deq_req stays 0 indefinitely.
- Full queue (q_count=4'hF or any value): no effect beyond the non-zero test.
- Width rules: TREAT_BASE*4 must fit in 6 bits (TREAT_BASE<=15). The product is computed in 6 bits with no truncation.
- Reset mid-TREAT: immediate return to IDLE. The patient is lost, no discharge pulse, served is cleared.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then doc_ready=1, q_count=0 for 20 cycles -> deq_req never high, busy=0, served=0.
- q_count=1, q_out=4'b1010, doc_ready=1 -> deq_req high 1 cycle, cur_pri=2, cur_id=2, busy high for 12 cycles of TREAT countdown (12..1), discharge pulse, served=1.
- Back-to-back: q_count=2, q_out=4'b1101 then 4'b0011 -> first treatment 16 cycles, second 4 cycles, exactly two deq_req pulses, served=2.
- doc_ready dropped mid-TREAT -> treatment completes with discharge; no new deq_req until doc_ready returns with q_count!=0.
- rst asserted asynchronously (between clock edges) with treat_left=5 -> all outputs 0 immediately, no discharge pulse, FSM in IDLE.
- DEQ_LAT=3 build: cur_id/cur_pri captured 3 cycles after deq_req; force served to 255 with one further discharge -> served stays 255.
